// File: rtl/haar_pkg.sv
// Shared types and default dimensions for the Haar lifting front end.
package haar_pkg;

  localparam int HAAR_DW    = 16;
  localparam int HAAR_IMG_W = 64;
  localparam int HAAR_IMG_H = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVEN_ROW = 2'd1,
    ODD_ROW  = 2'd2
  } state_t;

endpackage

// File: rtl/haar_line_ram.sv
// Single-row line buffer: synchronous write, registered read, contents never cleared.
module haar_line_ram #(
  parameter int DEPTH = 64,
  parameter int DW    = 16,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/haar_row_pairer.sv
// Buffers even rows and pairs them column-wise with the following odd row.
// Optional protocol error output enabled by defining HAAR_PAIR_ERR_EN.
module haar_row_pairer
  import haar_pkg::*;
#(
  parameter int DW    = HAAR_DW,
  parameter int IMG_W = HAAR_IMG_W,
  parameter int IMG_H = HAAR_IMG_H
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] pix_in,
  input  logic          pix_valid,
  input  logic          sof,
  output logic [DW-1:0] im11,
  output logic [DW-1:0] im21,
  output logic          start,
  output logic          frame_done
`ifdef HAAR_PAIR_ERR_EN
  ,
  output logic          err
`endif
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  state_t        state, state_n;
  logic [CW-1:0] col, col_n;
  logic [RW-1:0] row, row_n;

  logic          ram_we;
  logic [CW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata;
  logic          pair_fire, last_pair;
  logic          start_q, frame_done_q;
  logic [DW-1:0] pix_q;

  haar_line_ram #(
    .DEPTH(IMG_W),
    .DW   (DW),
    .AW   (CW)
  ) u_line_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(pix_in),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_n;
      col   <= col_n;
      row   <= row_n;
    end
  end

  // sof always wins, so a mid-frame sof silently restarts at (row 0, col 0)
  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    if (pix_valid) begin
      if (sof) begin
        state_n = EVEN_ROW;
        col_n   = CW'(1);
        row_n   = '0;
      end else begin
        case (state)
          EVEN_ROW: begin
            if (col == CW'(IMG_W - 1)) begin
              state_n = ODD_ROW;
              col_n   = '0;
              row_n   = row + RW'(1);
            end else begin
              col_n = col + CW'(1);
            end
          end
          ODD_ROW: begin
            if (col == CW'(IMG_W - 1)) begin
              col_n = '0;
              if (row == RW'(IMG_H - 1)) begin
                state_n = IDLE;
                row_n   = '0;
              end else begin
                state_n = EVEN_ROW;
                row_n   = row + RW'(1);
              end
            end else begin
              col_n = col + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    ram_we    = pix_valid && (sof || state == EVEN_ROW);
    ram_addr  = sof ? '0 : col;
    pair_fire = pix_valid && !sof && state == ODD_ROW;
    last_pair = pair_fire && col == CW'(IMG_W - 1) && row == RW'(IMG_H - 1);
    start      = start_q;
    frame_done = frame_done_q;
    im11       = start_q ? ram_rdata : '0;
    im21       = start_q ? pix_q : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      pix_q        <= '0;
    end else begin
      start_q      <= pair_fire;
      frame_done_q <= last_pair;
      if (pair_fire) pix_q <= pix_in;
    end
  end

`ifdef HAAR_PAIR_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else       err <= pix_valid && sof && state != IDLE;
  end
`endif

endmodule

// File: doc/haar_row_pairer.md
# haar_row_pairer

Upstream feeder for the Haar lifting stage. It takes a raster-order pixel stream and buffers each even image row in an on-chip line RAM. While the following odd row arrives, it emits vertically adjacent pixel pairs `im11` (even row) and `im21` (odd row) with a one-cycle `start` strobe. Its outputs connect directly to the lifting stage's `im11`/`im21`/`start` inputs.

## Interface
Parameters:
- `DW`, 16, pixel width; matches the lifting stage input width.
- `IMG_W`, 64, pixels per row; must be even and ≥ 2.
- `IMG_H`, 64, rows per frame; must be even and ≥ 2.

Ports:
- `clk`, in, 1, single clock for all logic.
- `reset`, in, 1, **synchronous, active-high** reset.
- `pix_in`, in, DW, raster pixel.
- `pix_valid`, in, 1, `pix_in` is valid this cycle.
- `sof`, in, 1, start of frame; qualified by `pix_valid` and marks pixel (row 0, col 0).
- `im11`, out, DW, pixel from the even row.
- `im21`, out, DW, pixel from the odd row, same column.
- `start`, out, 1, pair valid this cycle.
- `frame_done`, out, 1, one-cycle pulse together with the last pair of the frame.
- `err`, out, 1, protocol error pulse; present only with `HAAR_PAIR_ERR_EN`.

## Operation
- **States** (`state_t`): `IDLE`, `EVEN_ROW`, `ODD_ROW`.
- **Counters:** `col` has log2(IMG_W) bits and `row` has log2(IMG_H) bits.
- **IDLE:**
  - `pix_valid` without `sof` is ignored.
  - `pix_valid && sof` writes the pixel to RAM[0], sets `col=1`, `row=0`, and moves to `EVEN_ROW`.
- **EVEN_ROW:**
  - Each valid pixel is written to RAM[col], and `col` increments.
  - At `col==IMG_W-1`, the state moves to `ODD_ROW`, `col` wraps to 0, and `row` increments.
- **ODD_ROW:**
  - Each valid pixel reads RAM[col], and the pixel is registered alongside the read.
  - One cycle later the block drives `im11`=RAM data, `im21`=registered pixel, and `start=1`.
  - At `col==IMG_W-1`, `col` wraps and `row` increments.
  - If that was row IMG_H-1, the state moves to `IDLE` and `frame_done` pulses with that final pair. Otherwise the state moves to `EVEN_ROW`.
- **Output zeroing:** `im11`/`im21` are forced to 0 whenever `start=0`.
- **Gaps:** cycles with `pix_valid=0` freeze the counters and produce no `start`.
- **sof mid-frame** (`pix_valid && sof` outside IDLE): the block restarts the frame. The pixel becomes (row 0, col 0), the partial frame is discarded, and no `frame_done` is issued for it.
- **Stale data:** the RAM is not cleared on reset or restart. Stale data is never emitted, because an odd row always follows a fully written even row.
- **No backpressure:** the lifting stage accepts a pair every cycle.

## Timing
- **Reset values:** `state=IDLE`, counters 0, `start=0`, `im11=im21=0`, `frame_done=0`, `err=0`. All take effect on the first clock edge with `reset=1`.
- **Latency:** the odd-row pixel accepted at edge t produces `start`/data valid after edge t+1, i.e. a latency of 1 cycle.
- **Throughput:** one pair per cycle sustained.
- **RAM:** single-port behaviour suffices because even rows only write and odd rows only read. Read is synchronous, with data at t+1.
- **Reset mid-frame:** the in-flight pair is dropped, with `start=0` on the cycle after the reset edge.
- **Boundary pairing:** the last pixel of a row and the first pixel of the next row may arrive on consecutive cycles; no bubble is required.

## Configuration
- **`HAAR_PAIR_ERR_EN` defined:**
  - The `err` port exists.
  - `err` pulses for one cycle, registered and aligned with the next edge, on sof mid-frame.
  - Restart behaviour is unchanged.
- **`HAAR_PAIR_ERR_EN` undefined:**
  - The `err` port and its logic are absent.
  - All other behaviour is identical.

## Structure
- **Package `haar_pkg`:**
  - `HAAR_DW` = 16.
  - The `state_t` enum.
  - The default image dimensions, shared with the lifting stage.
- **Sub-module `haar_line_ram`:** an IMG_W × DW synchronous RAM with write enable, address, write data and registered read data.
- The FSM, counters and output registers live in the top module.

## Test plan
All scenarios use IMG_W=4, IMG_H=2.
- **Basic frame:**
  - Stimulus: `sof` with row 0 = 10,20,30,40, then row 1 = 1,2,3,4 on back-to-back valid cycles.
  - Response: 4 `start` pulses with (im11,im21) = (10,1),(20,2),(30,3),(40,4), one cycle after each odd pixel.
  - `frame_done` accompanies (40,4), and the block returns to IDLE.
- **Gaps:**
  - Stimulus: same frame with `pix_valid` low every other cycle.
  - Response: identical pairs, `start` only on the cycles following valid odd pixels, and zeros otherwise.
- **IDLE filtering:**
  - Stimulus: pixels with `pix_valid` but no `sof` while IDLE.
  - Response: no `start` and no state change.
  - A later `sof` frame pairs correctly.
- **sof mid-frame:**
  - Stimulus: `sof` at pixel (row 1, col 2).
  - Response: the restarted frame's pairs are correct, and no `frame_done` is issued for the aborted frame.
  - `err`=1 for one cycle if `HAAR_PAIR_ERR_EN` is defined.
- **Reset mid-frame:**
  - Stimulus: `reset` asserted during row 1.
  - Response: `start=0`, all outputs 0 the next cycle.
  - A fresh frame after deassertion produces correct pairs.
- **Back-to-back frames:**
  - Stimulus: two frames back-to-back, with the second `sof` on the cycle after the first frame's last pixel.
  - Response: 8 pairs, and `frame_done` twice.
